rtc_init_sequencer: RTL and testbench



---
 rtl/rtc_init_pkg.sv | 36 +++
 rtl/rtc_init_rom.sv | 26 ++
 rtl/rtc_init_sequencer.sv | 130 +++++++++++++
 tb/tb_rtc_init_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_init_pkg.sv
// Shared types and the default RTC power-on write table for the init sequencer.
package rtc_init_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StWaitAck = 3'd2,
    StDone    = 3'd3,
    StError   = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_entry_t;

  localparam int unsigned TABLE_LEN = 15;

  localparam init_entry_t INIT_TABLE [TABLE_LEN] = '{
    '{8'h02, 8'h10}, '{8'h10, 8'hD2}, '{8'h00, 8'h00}, '{8'h01, 8'h00},
    '{8'h21, 8'h00}, '{8'h22, 8'h00}, '{8'h23, 8'h00}, '{8'h24, 8'h00},
    '{8'h25, 8'h00}, '{8'h26, 8'h00}, '{8'h27, 8'h00}, '{8'h41, 8'h00},
    '{8'h42, 8'h00}, '{8'h43, 8'h00}, '{8'hF0, 8'h00}
  };

  // Entries past the end of the default table read as zero.
  function automatic init_entry_t init_entry(int unsigned i);
    init_entry_t e;
    e = '0;
    for (int unsigned k = 0; k < TABLE_LEN; k++) begin
      if (k == i) e = INIT_TABLE[k];
    end
    return e;
  endfunction

endpackage

// File: rtl/rtc_init_rom.sv
// Synchronous one-cycle-read ROM holding the init write table.
module rtc_init_rom
  import rtc_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  init_entry_t entry;

  always_comb begin
    entry = init_entry(32'(idx));
  end

  always_ff @(posedge clk) begin
    addr <= ADDR_W'(entry.addr);
    data <= DATA_W'(entry.data);
  end

endmodule

// File: rtl/rtc_init_sequencer.sv
// Power-on init sequencer: walks the RTC write table through a req/ack handshake
// with a per-entry ack timeout, flags completion or error, and re-runs on start.
module rtc_init_sequencer
  import rtc_init_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned N_ENTRIES      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_ack,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              escriba,
  output logic              inicializado,
  output logic              error,
  output logic [2:0]        auxiliar
);

  localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_ENTRIES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rom_addr;
  logic [DATA_W-1:0] data_q, data_d, rom_data;
  logic              escriba_q, init_q, error_q;

  // ROM is addressed with the next index so its output is valid during FETCH.
  rtc_init_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_rom (
    .clk  (clk),
    .idx  (idx_d),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if ((AUTO_START != 0) || start) state_d = StFetch;
      end
      StFetch: begin
        addr_d  = rom_addr;
        data_d  = rom_data;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wr_ack) begin
          req_d = 1'b0;
          if (idx_q == LastIdx) begin
            addr_d  = '0;
            data_d  = '0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StFetch;
          end
        end else if (cnt_q == CntMax) begin
          req_d   = 1'b0;
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone, StError: begin
        if (start) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      escriba_q <= 1'b0;
      init_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      escriba_q <= (state_d == StFetch) || (state_d == StWaitAck);
      init_q    <= (state_d == StDone);
      error_q   <= (state_d == StError);
    end
  end

  assign wr_req       = req_q;
  assign wr_addr      = addr_q;
  assign wr_data      = data_q;
  assign escriba      = escriba_q;
  assign inicializado = init_q;
  assign error        = error_q;
  assign auxiliar     = state_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Directed bench: table of expected writes with per-entry ack delays, plus
// hand sequences for timeout, restart, mid-run reset and manual-start behaviour.
module tb_rtc_init_sequencer;

  localparam int unsigned NE = 15;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1, start_a = 1'b0, ack_a = 1'b0;
  logic       wr_req, escriba, inicializado, error;
  logic [7:0] wr_addr, wr_data;
  logic [2:0] auxiliar;

  logic       reset_m = 1'b1, start_m = 1'b0, ack_m = 1'b0;
  logic       req_m, esc_m, init_m, err_m;
  logic [7:0] addr_m, data_m;
  logic [2:0] aux_m;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned ack_delay;
  } vec_t;

  vec_t vecs [NE];

  always #5 clk = ~clk;

  rtc_init_sequencer #(
    .TIMEOUT_CYCLES (16),
    .AUTO_START     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset_a),
    .start        (start_a),
    .wr_ack       (ack_a),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .escriba      (escriba),
    .inicializado (inicializado),
    .error        (error),
    .auxiliar     (auxiliar)
  );

  rtc_init_sequencer #(
    .TIMEOUT_CYCLES (16),
    .AUTO_START     (0)
  ) dut_m (
    .clk          (clk),
    .reset        (reset_m),
    .start        (start_m),
    .wr_ack       (ack_m),
    .wr_req       (req_m),
    .wr_addr      (addr_m),
    .wr_data      (data_m),
    .escriba      (esc_m),
    .inicializado (init_m),
    .error        (err_m),
    .auxiliar     (aux_m)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(output int unsigned waited);
    waited = 0;
    while (!wr_req && waited < 64) begin
      tick();
      waited++;
    end
  endtask

  // Serves entries 0..upto-1 with the table's ack delays; completion is checked
  // when the whole table has been served.
  task automatic run_entries(input int unsigned upto);
    int unsigned waited;
    for (int unsigned i = 0; i < upto; i++) begin
      wait_req(waited);
      check("req_rise", 32'(wr_req), 1);
      if (i != 0) check("fetch_gap", waited, 1);
      check("addr", 32'(wr_addr), 32'(vecs[i].addr));
      check("data", 32'(wr_data), 32'(vecs[i].data));
      check("escriba_busy", 32'(escriba), 1);
      for (int unsigned d = 0; d < vecs[i].ack_delay; d++) tick();
      check("req_hold", 32'(wr_req), 1);
      check("addr_hold", 32'(wr_addr), 32'(vecs[i].addr));
      check("no_err_before_ack", 32'(error), 0);
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;
      check("req_drop", 32'(wr_req), 0);
      if (i == NE - 1) begin
        check("done_aux", 32'(auxiliar), 3);
        check("done_init", 32'(inicializado), 1);
        check("done_escriba", 32'(escriba), 0);
        check("done_error", 32'(error), 0);
        check("done_addr", 32'(wr_addr), 0);
        check("done_data", 32'(wr_data), 0);
      end else begin
        check("fetch_aux", 32'(auxiliar), 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned waited;
    logic        seen;

    vecs[0]  = '{8'h02, 8'h10, 3};
    vecs[1]  = '{8'h10, 8'hD2, 0};
    vecs[2]  = '{8'h00, 8'h00, 1};
    vecs[3]  = '{8'h01, 8'h00, 3};
    vecs[4]  = '{8'h21, 8'h00, 3};
    vecs[5]  = '{8'h22, 8'h00, 15};  // ack lands on the timeout edge
    vecs[6]  = '{8'h23, 8'h00, 14};
    vecs[7]  = '{8'h24, 8'h00, 3};
    vecs[8]  = '{8'h25, 8'h00, 3};
    vecs[9]  = '{8'h26, 8'h00, 2};
    vecs[10] = '{8'h27, 8'h00, 3};
    vecs[11] = '{8'h41, 8'h00, 3};
    vecs[12] = '{8'h42, 8'h00, 0};
    vecs[13] = '{8'h43, 8'h00, 3};
    vecs[14] = '{8'hF0, 8'h00, 3};

    repeat (3) tick();
    check("rst_req", 32'(wr_req), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_escriba", 32'(escriba), 0);
    check("rst_init", 32'(inicializado), 0);
    check("rst_error", 32'(error), 0);
    check("rst_aux", 32'(auxiliar), 0);

    // Manual-start instance: idle until start, start ignored while busy.
    reset_m = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (req_m) seen = 1'b1;
    end
    check("m_no_autostart", 32'(seen), 0);
    check("m_idle_aux", 32'(aux_m), 0);
    ack_m = 1'b1;
    tick();
    ack_m = 1'b0;
    check("m_idle_ack_ignored", 32'(aux_m), 0);
    check("m_idle_ack_req", 32'(req_m), 0);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("m_start_fetch", 32'(aux_m), 1);
    tick();
    check("m_first_req", 32'(req_m), 1);
    check("m_first_addr", 32'(addr_m), 32'h02);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("m_start_in_wait_aux", 32'(aux_m), 2);
    check("m_start_in_wait_addr", 32'(addr_m), 32'h02);
    ack_m = 1'b1;
    tick();
    ack_m = 1'b0;
    check("m_fetch_aux", 32'(aux_m), 1);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("m_start_in_fetch_aux", 32'(aux_m), 2);
    check("m_start_in_fetch_addr", 32'(addr_m), 32'h10);
    check("m_start_in_fetch_data", 32'(data_m), 32'hD2);
    reset_m = 1'b1;

    // Auto-start: wr_req rises after the second edge with reset low.
    reset_a = 1'b0;
    tick();
    check("auto_fetch_aux", 32'(auxiliar), 1);
    check("auto_fetch_req", 32'(wr_req), 0);
    check("auto_fetch_escriba", 32'(escriba), 1);
    tick();
    check("auto_req", 32'(wr_req), 1);
    check("auto_aux", 32'(auxiliar), 2);
    run_entries(NE);

    // Spurious ack in DONE, then rerun with entry 4 never acked.
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    check("done_ack_ignored_init", 32'(inicializado), 1);
    check("done_ack_ignored_aux", 32'(auxiliar), 3);
    check("done_ack_ignored_req", 32'(wr_req), 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("rerun_aux", 32'(auxiliar), 1);
    check("rerun_init_clr", 32'(inicializado), 0);
    run_entries(4);
    wait_req(waited);
    check("to_req", 32'(wr_req), 1);
    check("to_addr", 32'(wr_addr), 32'h21);
    repeat (15) tick();
    check("to_pre_error", 32'(error), 0);
    check("to_pre_req", 32'(wr_req), 1);
    tick();
    check("to_error", 32'(error), 1);
    check("to_req_drop", 32'(wr_req), 0);
    check("to_aux", 32'(auxiliar), 4);
    check("to_escriba", 32'(escriba), 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_req) seen = 1'b1;
    end
    check("to_quiet", 32'(seen), 0);
    check("to_error_held", 32'(error), 1);

    // Retry from ERROR.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("retry_error_clr", 32'(error), 0);
    check("retry_aux", 32'(auxiliar), 1);
    run_entries(NE);

    // Reset while waiting on entry 7, then auto rerun from entry 0.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_entries(7);
    wait_req(waited);
    check("e7_addr", 32'(wr_addr), 32'h24);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("mid_rst_req", 32'(wr_req), 0);
    check("mid_rst_addr", 32'(wr_addr), 0);
    check("mid_rst_data", 32'(wr_data), 0);
    check("mid_rst_escriba", 32'(escriba), 0);
    check("mid_rst_aux", 32'(auxiliar), 0);
    tick();
    check("post_rst_fetch", 32'(auxiliar), 1);
    tick();
    check("post_rst_req", 32'(wr_req), 1);
    check("post_rst_addr", 32'(wr_addr), 32'h02);
    run_entries(NE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
